ftrace_event_buffer: RTL and testbench
======================================

# ftrace_event_buffer

Parametrised function-trace front end for the simulation harness. It watches up to CHANNELS committed instructions per cycle and classifies jal/jalr as calls or returns. It maintains a shadow return-address stack and queues timestamp-free trace records in a FIFO. The DPI sink drains that FIFO over a valid/ready handshake. It sits beside the commit stage and never stalls the core: records that do not fit are dropped and counted.

## Interface
- XLEN, 32, data/address width
- CHANNELS, 2, commit lanes per cycle (1..4), lane 0 oldest
- FIFO_DEPTH, 8, record queue entries (power of two, ≥ CHANNELS)
- STACK_DEPTH, 16, shadow stack entries (power of two)
- DW = clog2(STACK_DEPTH+1)

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- in_valid  in  CHANNELS  lane i committed this cycle
- in_pc  in  CHANNELS*XLEN  lane i pc
- in_nextpc  in  CHANNELS*XLEN  lane i actual next pc
- in_inst  in  CHANNELS*32  lane i instruction
- out_valid  out  1  record available
- out_ready  in  1  sink accepts record
- out_kind  out  2  01 call, 10 return
- out_pc  out  XLEN  pc of the jump
- out_target  out  XLEN  nextpc of the jump
- out_depth  out  DW  stack depth after the operation
- out_mismatch  out  1  return target ≠ stack top, or underflow
- drop_count  out  16  saturating dropped-record count
- stack_overflow  out  1  sticky: a push hit a full stack

## Operation
- Call: valid lane with opcode 1101111 (jal) or 1100111 (jalr), rd ∈ {x1, x5}. Push pc+4. Record kind 01.
- Return: jalr with rd = x0, rs1 ∈ {x1, x5}, imm = 0. Pop. Record kind 10.
- Any other instruction produces no record and no stack change.
- jalr with rd ∈ {x1, x5} is always treated as a call, whatever rs1 is.
- Lanes are processed in order 0..CHANNELS-1 within one cycle. Each lane sees the stack state left by the lower lanes.
- Push on a full stack (depth = STACK_DEPTH):
  - Write to the circular top and overwrite the oldest entry.
  - depth stays STACK_DEPTH.
  - stack_overflow sets to 1 and stays set until reset.
- Pop with depth > 0:
  - mismatch = (in_nextpc ≠ top entry).
  - depth decrements.
- Pop with depth = 0 (underflow): mismatch = 1, depth stays 0, pointer unchanged.
- Record fields: kind, pc, target = in_nextpc, depth after the operation, mismatch (always 0 for calls).
- FIFO admission:
  - free = FIFO_DEPTH − count, using count at the start of the cycle; a same-cycle pop does not add space.
  - The first `free` records of the cycle, in lane order, are written.
  - Remaining records are dropped; drop_count += number dropped, saturating at 0xFFFF.
  - The stack is updated for every classified lane, whether or not its record was dropped.
- Drain: out_* show the FIFO head. The head is popped when out_valid && out_ready. out_* are stable while out_valid && !out_ready.

## Timing
- Reset values (when reset = 0 at a clock edge):
  - out_valid 0
  - FIFO count and pointers 0
  - stack depth and pointer 0
  - drop_count 0
  - stack_overflow 0
  - out_kind, out_pc, out_target, out_depth, out_mismatch read 0 while out_valid = 0
- Reset mid-operation discards all queued records and stack contents. A lane valid during the reset cycle is ignored.
- Latency: a commit at cycle N appears on out_* at N+1 at the earliest, if the FIFO was empty.
- Throughput: up to CHANNELS writes and 1 read per cycle.
- Full FIFO with out_ready = 1: pop at edge N, new records dropped at N. Space becomes visible at N+1.
- Empty FIFO: out_valid = 0; out_ready is ignored.
- Depth arithmetic is unsigned, saturating at 0 and STACK_DEPTH. Stack index wraps modulo STACK_DEPTH.

## Test plan
- Single lane:
  - jal x1 at pc 0x80000000 → 0x80000100. Record {01, 0x80000000, 0x80000100, depth 1, mm 0}.
  - Then jalr x0,0(x1) at 0x80000104 → 0x80000004. Record {10, depth 0, mm 0}.
- Same-cycle lanes: lane0 call at pc 0x100 (push 0x104), lane1 return to 0x104. Two records in order: depths 1 then 0, lane1 mm 0.
- Drop:
  - out_ready = 0, 5 cycles of dual-lane calls with FIFO_DEPTH 8. Exactly 8 records are queued and drop_count = 2.
  - Stack depth = 10.
  - Drained records appear in lane/program order.
- Underflow: return at depth 0 → {10, depth 0, mm 1}. Return to a wrong target at depth 3 → mm 1, depth 2.
- Overflow: 17 calls with STACK_DEPTH 16 → depth 16, stack_overflow = 1. The 16 following returns match the newest 16 addresses; the 17th return underflows.
- Reset: assert reset while 4 records are queued and the output is stalled. Next cycle out_valid = 0, drop_count = 0, and a new call reports depth 1.

Source files
------------

// File: rtl/ftrace_event_buffer.sv
// Function-trace front end: classifies committed jal/jalr as calls/returns, tracks a shadow
// return-address stack and queues trace records for a valid/ready sink, dropping what does not fit.
module ftrace_event_buffer #(
    parameter int XLEN        = 32,
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [CHANNELS*XLEN-1:0] in_pc,
    input  logic [CHANNELS*XLEN-1:0] in_nextpc,
    input  logic [CHANNELS*32-1:0]   in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_target,
    output logic [DW-1:0]            out_depth,
    output logic                     out_mismatch,
    output logic [15:0]              drop_count,
    output logic                     stack_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STACK_DEPTH);

    typedef struct packed {
        logic [1:0]      kind;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic [DW-1:0]   depth;
        logic            mismatch;
    } rec_t;

    logic [CHANNELS-1:0] is_call;
    logic [CHANNELS-1:0] is_ret;
    logic [XLEN-1:0]     lane_pc     [CHANNELS];
    logic [XLEN-1:0]     lane_nextpc [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [31:0] inst;
            logic        is_jal;
            logic        is_jalr;
            logic        rd_link;
            logic        rs1_link;
            assign inst             = in_inst[gi*32 +: 32];
            assign lane_pc[gi]      = in_pc[gi*XLEN +: XLEN];
            assign lane_nextpc[gi]  = in_nextpc[gi*XLEN +: XLEN];
            assign is_jal           = (inst[6:0] == 7'b1101111);
            assign is_jalr          = (inst[6:0] == 7'b1100111) && (inst[14:12] == 3'b000);
            assign rd_link          = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
            assign rs1_link         = (inst[19:15] == 5'd1) || (inst[19:15] == 5'd5);
            // A linking rd always wins, so rd = x0 is the only way a jalr can be a return
            assign is_call[gi]      = in_valid[gi] && (is_jal || is_jalr) && rd_link;
            assign is_ret[gi]       = in_valid[gi] && is_jalr && (inst[11:7] == 5'd0) &&
                                      rs1_link && (inst[31:20] == 12'd0);
        end
    endgenerate

    logic [XLEN-1:0] stack_reg  [STACK_DEPTH];
    logic [XLEN-1:0] stack_next [STACK_DEPTH];
    logic [SW-1:0]   sp_reg, sp_next, top_idx;
    logic [DW-1:0]   depth_reg, depth_next;
    logic            ovf_reg, ovf_next;

    rec_t            fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [15:0]     drop_reg;
    logic [16:0]     drop_sum;
    logic            pop;
    rec_t            head;

    rec_t            lane_rec  [CHANNELS];
    logic [AW-1:0]   lane_slot [CHANNELS];
    logic [CHANNELS-1:0] lane_wr;
    int              n_rec;
    int              n_wr;
    int              free_slots;

    // Lanes walk the stack in order so each one sees what the lower lanes left behind
    always_comb begin
        stack_next = stack_reg;
        sp_next    = sp_reg;
        depth_next = depth_reg;
        ovf_next   = ovf_reg;
        top_idx    = '0;
        lane_wr    = '0;
        n_rec      = 0;
        n_wr       = 0;
        free_slots = FIFO_DEPTH - int'(count_reg);
        for (int i = 0; i < CHANNELS; i++) begin
            lane_rec[i]  = '0;
            lane_slot[i] = '0;
            if (is_call[i] || is_ret[i]) begin
                lane_rec[i].pc     = lane_pc[i];
                lane_rec[i].target = lane_nextpc[i];
                if (is_call[i]) begin
                    lane_rec[i].kind    = 2'b01;
                    stack_next[sp_next] = lane_pc[i] + XLEN'(4);
                    sp_next             = sp_next + SW'(1);
                    if (depth_next == DW'(STACK_DEPTH)) begin
                        ovf_next = 1'b1;
                    end else begin
                        depth_next = depth_next + DW'(1);
                    end
                end else begin
                    lane_rec[i].kind = 2'b10;
                    if (depth_next == '0) begin
                        lane_rec[i].mismatch = 1'b1;
                    end else begin
                        top_idx              = sp_next - SW'(1);
                        lane_rec[i].mismatch = (lane_nextpc[i] != stack_next[top_idx]);
                        sp_next              = top_idx;
                        depth_next           = depth_next - DW'(1);
                    end
                end
                lane_rec[i].depth = depth_next;
                if (n_rec < free_slots) begin
                    lane_wr[i]   = 1'b1;
                    lane_slot[i] = wr_ptr_reg + AW'(n_wr);
                    n_wr         = n_wr + 1;
                end
                n_rec = n_rec + 1;
            end
        end
    end

    assign drop_sum  = {1'b0, drop_reg} + 17'(n_rec - n_wr);
    assign head      = fifo_mem[rd_ptr_reg];
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp_reg     <= '0;
            depth_reg  <= '0;
            ovf_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            sp_reg     <= sp_next;
            depth_reg  <= depth_next;
            ovf_reg    <= ovf_next;
            wr_ptr_reg <= wr_ptr_reg + AW'(n_wr);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            count_reg  <= count_reg + CW'(n_wr) - CW'(pop);
            drop_reg   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Storage needs no reset: depth and FIFO count gate everything that is read
    always_ff @(posedge clock) begin
        stack_reg <= stack_next;
        for (int i = 0; i < CHANNELS; i++) begin
            if (lane_wr[i]) begin
                fifo_mem[lane_slot[i]] <= lane_rec[i];
            end
        end
    end

    assign out_kind       = out_valid ? head.kind     : '0;
    assign out_pc         = out_valid ? head.pc       : '0;
    assign out_target     = out_valid ? head.target   : '0;
    assign out_depth      = out_valid ? head.depth    : '0;
    assign out_mismatch   = out_valid ? head.mismatch : 1'b0;
    assign drop_count     = drop_reg;
    assign stack_overflow = ovf_reg;
endmodule

// File: tb/tb_ftrace_event_buffer.sv
// Bench for ftrace_event_buffer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the return stack and record FIFO.
module tb_ftrace_event_buffer;
    localparam int XLEN = 32;
    localparam int CH   = 2;
    localparam int FD   = 8;
    localparam int SD   = 16;
    localparam int DW   = 5;
    localparam int RW   = 2 + 2*XLEN + DW + 1;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [CH-1:0]       in_valid = '0;
    logic [CH*XLEN-1:0]  in_pc = '0;
    logic [CH*XLEN-1:0]  in_nextpc = '0;
    logic [CH*32-1:0]    in_inst = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [1:0]          out_kind;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_target;
    logic [DW-1:0]       out_depth;
    logic                out_mismatch;
    logic [15:0]         drop_count;
    logic                stack_overflow;
    logic [RW-1:0]       out_rec;

    ftrace_event_buffer #(
        .XLEN(XLEN), .CHANNELS(CH), .FIFO_DEPTH(FD), .STACK_DEPTH(SD)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_nextpc(in_nextpc), .in_inst(in_inst), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc),
        .out_target(out_target), .out_depth(out_depth), .out_mismatch(out_mismatch),
        .drop_count(drop_count), .stack_overflow(stack_overflow)
    );

    always #5 clock = ~clock;
    assign out_rec = {out_kind, out_pc, out_target, out_depth, out_mismatch};

    logic [XLEN-1:0] mstack[$];
    logic [RW-1:0]   mq[$];
    int              mdrop = 0;
    bit              movf = 1'b0;
    int              errors = 0;
    int              checks = 0;

    function automatic logic [31:0] jal(input int rd);
        return {20'h00010, 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
    endfunction

    function automatic logic [RW-1:0] mkrec(input logic [1:0] k, input logic [31:0] pc,
                                            input logic [31:0] tgt, input int d, input bit mm);
        return {k, pc, tgt, DW'(d), mm};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic [31:0] npc, input logic [31:0] inst);
        in_valid[i]               = v;
        in_pc[i*XLEN +: XLEN]     = pc;
        in_nextpc[i*XLEN +: XLEN] = npc;
        in_inst[i*32 +: 32]       = inst;
    endtask

    task automatic clear_lanes();
        in_valid  = '0;
        in_pc     = '0;
        in_nextpc = '0;
        in_inst   = '0;
    endtask

    // Apply the rules to the inputs as they stand just before the edge
    task automatic model_edge();
        int free_slots;
        int nrec;
        bit do_pop;
        if (!reset) begin
            mstack.delete();
            mq.delete();
            mdrop = 0;
            movf  = 1'b0;
            return;
        end
        free_slots = FD - mq.size();
        do_pop     = (mq.size() > 0) && out_ready;
        nrec       = 0;
        for (int i = 0; i < CH; i++) begin
            logic [31:0] inst;
            logic [31:0] pc;
            logic [31:0] npc;
            bit          call;
            bit          ret;
            bit          mm;
            int          rd;
            int          rs1;
            inst = in_inst[i*32 +: 32];
            pc   = in_pc[i*XLEN +: XLEN];
            npc  = in_nextpc[i*XLEN +: XLEN];
            rd   = int'(inst[11:7]);
            rs1  = int'(inst[19:15]);
            call = in_valid[i] && (rd == 1 || rd == 5) &&
                   (inst[6:0] == 7'b1101111 || (inst[6:0] == 7'b1100111 && inst[14:12] == 3'd0));
            ret  = in_valid[i] && !call && inst[6:0] == 7'b1100111 && inst[14:12] == 3'd0 &&
                   rd == 0 && (rs1 == 1 || rs1 == 5) && inst[31:20] == 12'd0;
            mm   = 1'b0;
            if (call) begin
                if (mstack.size() == SD) begin
                    void'(mstack.pop_front());
                    movf = 1'b1;
                end
                mstack.push_back(pc + 32'd4);
            end else if (ret) begin
                if (mstack.size() == 0) mm = 1'b1;
                else mm = (npc != mstack.pop_back());
            end
            if (call || ret) begin
                if (nrec < free_slots) mq.push_back(mkrec(call ? 2'b01 : 2'b10, pc, npc, mstack.size(), mm));
                else if (mdrop < 65535) mdrop++;
                nrec++;
            end
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    task automatic compare();
        check("out_valid", 80'(out_valid), 80'(mq.size() != 0));
        if (mq.size() != 0) check("head_record", 80'(out_rec), 80'(mq[0]));
        else check("idle_record", 80'(out_rec), 80'(0));
        check("drop_count", 80'(drop_count), 80'(mdrop));
        check("stack_overflow", 80'(stack_overflow), 80'(movf));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        clear_lanes();
        repeat (9) step();
    endtask

    initial begin
        step();
        step();
        reset = 1'b1;

        // single-lane call then return
        out_ready = 1'b1;
        set_lane(0, 1'b1, 32'h80000000, 32'h80000100, jal(1));
        step();
        check("jal_rec", 80'(out_rec), 80'(mkrec(2'b01, 32'h80000000, 32'h80000100, 1, 1'b0)));
        set_lane(0, 1'b1, 32'h80000104, 32'h80000004, jalr(0, 1, 0));
        step();
        check("ret_rec", 80'(out_rec), 80'(mkrec(2'b10, 32'h80000104, 32'h80000004, 0, 1'b0)));
        clear_lanes();
        step();

        // call and matching return in the same cycle
        out_ready = 1'b0;
        set_lane(0, 1'b1, 32'h100, 32'h200, jal(1));
        set_lane(1, 1'b1, 32'h200, 32'h104, jalr(0, 1, 0));
        step();
        clear_lanes();
        check("pair_first", 80'(out_rec), 80'(mkrec(2'b01, 32'h100, 32'h200, 1, 1'b0)));
        out_ready = 1'b1;
        step();
        check("pair_second", 80'(out_rec), 80'(mkrec(2'b10, 32'h200, 32'h104, 0, 1'b0)));
        drain();

        // overfill the FIFO with the sink stalled
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < CH; i++) set_lane(i, 1'b1, 32'h1000 + 32'((c*2 + i) * 8), 32'h2000, jal(1));
            step();
        end
        check("drop_two", 80'(drop_count), 80'(2));
        check("drop_head", 80'(out_rec), 80'(mkrec(2'b01, 32'h1000, 32'h2000, 1, 1'b0)));
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) set_lane(i, 1'b1, 32'h1000 + 32'((10 + i) * 8), 32'h2000, jal(1));
        step();
        check("full_pop_drop", 80'(drop_count), 80'(4));
        check("full_pop_head", 80'(out_rec), 80'(mkrec(2'b01, 32'h1008, 32'h2000, 2, 1'b0)));
        drain();
        out_ready = 1'b0;
        set_lane(0, 1'b1, 32'h3000, 32'h105C, jalr(0, 1, 0));
        step();
        check("depth_after_drop", 80'(out_rec), 80'(mkrec(2'b10, 32'h3000, 32'h105C, 11, 1'b0)));
        drain();

        // reset with records queued and the sink stalled
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < CH; i++) set_lane(i, 1'b1, 32'h400 + 32'((c*2 + i) * 4), 32'h2000, jal(5));
            step();
        end
        reset = 1'b0;
        step();
        check("rst_valid", 80'(out_valid), 80'(0));
        check("rst_drop", 80'(drop_count), 80'(0));
        reset = 1'b1;
        clear_lanes();
        set_lane(0, 1'b1, 32'h500, 32'h600, jal(5));
        step();
        check("post_rst_depth", 80'(out_rec), 80'(mkrec(2'b01, 32'h500, 32'h600, 1, 1'b0)));

        // underflow, then wrong return target
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_lanes();
        set_lane(0, 1'b1, 32'h700, 32'h123, jalr(0, 5, 0));
        step();
        check("underflow", 80'(out_rec), 80'(mkrec(2'b10, 32'h700, 32'h123, 0, 1'b1)));
        drain();
        set_lane(0, 1'b1, 32'h800, 32'h2000, jal(1));
        set_lane(1, 1'b1, 32'h810, 32'h2000, jalr(1, 7, 8));
        step();
        clear_lanes();
        set_lane(0, 1'b1, 32'h820, 32'h2000, jal(5));
        step();
        drain();
        out_ready = 1'b0;
        set_lane(0, 1'b1, 32'h900, 32'hDEAD0, jalr(0, 1, 0));
        step();
        check("wrong_target", 80'(out_rec), 80'(mkrec(2'b10, 32'h900, 32'hDEAD0, 2, 1'b1)));
        drain();

        // stack overflow: 17 calls then 17 returns
        reset = 1'b0;
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_lane(0, 1'b1, 32'h4000 + 32'(k * 16), 32'h9000, jal(1));
            step();
        end
        check("ovf_flag", 80'(stack_overflow), 80'(1));
        check("ovf_depth", 80'(out_depth), 80'(16));
        for (int j = 0; j < 16; j++) begin
            set_lane(0, 1'b1, 32'h6000, 32'h4000 + 32'((16 - j) * 16 + 4), jalr(0, 1, 0));
            step();
            check("ovf_ret_mm", 80'(out_mismatch), 80'(0));
            check("ovf_ret_depth", 80'(out_depth), 80'(15 - j));
        end
        set_lane(0, 1'b1, 32'h6000, 32'h4004, jalr(0, 1, 0));
        step();
        check("ovf_last_mm", 80'(out_mismatch), 80'(1));
        check("ovf_last_depth", 80'(out_depth), 80'(0));
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < CH; i++) begin
                int          sel;
                logic [31:0] pc;
                logic [31:0] tgt;
                logic [31:0] inst;
                sel = $urandom_range(0, 7);
                pc  = $urandom & 32'hFFFFFFFC;
                tgt = $urandom & 32'hFFFFFFFC;
                if ($urandom_range(0, 1) == 1 && mstack.size() > 0) tgt = mstack[$];
                case (sel)
                    0:       inst = jal(1);
                    1:       inst = jal(5);
                    2:       inst = jalr(1, $urandom_range(0, 31), $urandom_range(0, 4095));
                    3:       inst = jalr(0, 1, 0);
                    4:       inst = jalr(0, 5, 0);
                    5:       inst = jalr(0, 1, 4);
                    6:       inst = 32'h00108093;
                    default: inst = jal(0);
                endcase
                set_lane(i, ($urandom_range(0, 3) != 0), pc, tgt, inst);
            end
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
